// File: rtl/mul_arb.sv
// Two-port arbiter in front of one shared 64-bit multiplier, with at most one request in flight.
// Define MUL_ARB_RR_EN for round-robin arbitration; otherwise port 0 always wins a conflict.
module mul_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] p0_operand1,
  input  logic [63:0] p0_operand2,
  input  logic [2:0]  p0_mul_op,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  output logic [63:0] p0_resp_result,
  output logic        p0_resp_valid,
  input  logic        p0_resp_ready,
  input  logic [63:0] p1_operand1,
  input  logic [63:0] p1_operand2,
  input  logic [2:0]  p1_mul_op,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  output logic [63:0] p1_resp_result,
  output logic        p1_resp_valid,
  input  logic        p1_resp_ready,
  output logic [63:0] m_operand1,
  output logic [63:0] m_operand2,
  output logic [2:0]  m_mul_op,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  input  logic [63:0] m_resp_result,
  input  logic        m_resp_valid,
  output logic        m_resp_ready
);

  logic r_busy;
  logic r_owner;
  logic w_prio;
  logic w_sel;
  logic w_any;
  logic w_owner_rdy;
  logic w_resp_hs;
  logic w_window;
  logic w_issue;

`ifdef MUL_ARB_RR_EN
  logic r_prio;
  assign w_prio = r_prio;
`else
  assign w_prio = 1'b0;
`endif

  // Selection defaults to port 0 so the multiplier operands are stable when idle.
  always_comb begin
    w_sel = 1'b0;
    if (p0_req_valid && p1_req_valid)
      w_sel = w_prio;
    else if (p1_req_valid)
      w_sel = 1'b1;
  end

  assign w_any       = p0_req_valid | p1_req_valid;
  assign w_owner_rdy = r_owner ? p1_resp_ready : p0_resp_ready;

  // Outputs are forced quiet while rst is high so nothing handshakes in the reset cycle.
  assign m_resp_ready = !rst && r_busy && w_owner_rdy;
  assign w_resp_hs    = m_resp_valid && m_resp_ready;
  assign w_window     = !r_busy || w_resp_hs;
  assign m_req_valid  = !rst && w_window && w_any;
  assign w_issue      = m_req_valid && m_req_ready;

  assign m_operand1 = w_sel ? p1_operand1 : p0_operand1;
  assign m_operand2 = w_sel ? p1_operand2 : p0_operand2;
  assign m_mul_op   = w_sel ? p1_mul_op   : p0_mul_op;

  assign p0_req_ready = w_issue && !w_sel;
  assign p1_req_ready = w_issue &&  w_sel;

  assign p0_resp_valid  = !rst && r_busy && m_resp_valid && !r_owner;
  assign p1_resp_valid  = !rst && r_busy && m_resp_valid &&  r_owner;
  assign p0_resp_result = m_resp_result;
  assign p1_resp_result = m_resp_result;

  // A same-cycle issue keeps busy set and retargets the owner to the new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_owner <= 1'b0;
    end else if (w_issue) begin
      r_busy  <= 1'b1;
      r_owner <= w_sel;
    end else if (w_resp_hs) begin
      r_busy  <= 1'b0;
    end
  end

`ifdef MUL_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_prio <= 1'b0;
    else if (w_issue)
      r_prio <= ~w_sel;
  end
`endif

endmodule
